// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the DMEM port arbiter: default geometry, FSM
// state encoding and a counter-width helper.
package dmem_port_arbiter_pkg;

    localparam int DMEM_AW         = 12;
    localparam int DMEM_DW         = 32;
    localparam int DMEM_STARVE_MAX = 16;

    // NORMAL: CPU has fixed priority. FORCE: one-cycle loader grant.
    typedef enum logic {
        STATE_NORMAL = 1'b0,
        STATE_FORCE  = 1'b1
    } arbState_t;

    // Bits needed to hold 0..maxVal; at least one bit so a disabled
    // counter (maxVal == 0) still has a legal vector width.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating loader-wait counter with synchronous clear and a
// terminal-count flag raised when the count sits at MAX-1.
module starve_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX = 16
)(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam int W = cntWidth(MAX);
    localparam logic [W-1:0] SAT_VAL = W'(MAX);
    localparam logic [W-1:0] TC_VAL  = (MAX == 0) ? '0 : W'(MAX - 1);

    logic [W-1:0] count;

    // Count refused cycles; clear wins over increment, stop at MAX.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SAT_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (MAX != 0) && (count == TC_VAL);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous DMEM port between the CPU X-stage load/store
// path (fixed priority) and a background loader on a valid/ready
// handshake. A starved loader gets one forced grant while the CPU stalls
// for a cycle. Read data is routed to whoever issued the read.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
)(
    input  logic            clk,
    input  logic            rst,
    // CPU X-stage port
    input  logic            cpu_rd,
    input  logic [DW/8-1:0] cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_din,
    output logic            cpu_stall,
    output logic [DW-1:0]   cpu_rdata,
    // Loader port
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [DW/8-1:0] ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_din,
    output logic            ld_rsp_valid,
    output logic [DW-1:0]   ld_rsp_data,
    // DMEM port
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout
);

    arbState_t state;
    arbState_t stateNext;
    logic      cpuReq;
    logic      grantCpu;
    logic      grantLd;
    logic      xferLd;
    logic      refusedLd;
    logic      starveTc;
    logic      rspOwnerQ;

    assign cpuReq    = cpu_rd | (|cpu_we);
    assign xferLd    = ld_valid & grantLd;
    assign refusedLd = ld_valid & ~grantLd;

    // Combinational grant: loader owns FORCE cycles, CPU wins otherwise.
    // Grants are held off during reset so the port stays quiet.
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (which infers a latch).
    always_comb begin
        grantCpu = 1'b0;
        grantLd  = 1'b0;
        if (!rst) begin
            unique case (state)
                STATE_FORCE: begin
                    grantLd = ld_valid;
                end
                default: begin
                    if (cpuReq) begin
                        grantCpu = 1'b1;
                    end else begin
                        grantLd = ld_valid;
                    end
                end
            endcase
        end
    end

    // Port mux: idle cycles write nothing and park addr/din on the CPU.
    always_comb begin
        mem_we   = '0;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        if (grantCpu) begin
            mem_we = cpu_we;
        end else if (grantLd) begin
            mem_we   = ld_we;
            mem_addr = ld_addr;
            mem_din  = ld_din;
        end
    end

    assign ld_ready  = grantLd;
    assign cpu_stall = (state == STATE_FORCE) & cpuReq;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (refusedLd),
        .clr (xferLd | ~ld_valid),
        .tc  (starveTc)
    );

    // Next state: enter FORCE when the loader is refused at MAX-1 waits;
    // FORCE always lasts a single cycle.
    always_comb begin
        stateNext = state;
        unique case (state)
            STATE_NORMAL: begin
                if (starveTc && refusedLd) begin
                    stateNext = STATE_FORCE;
                end
            end
            STATE_FORCE: begin
                stateNext = STATE_NORMAL;
            end
            default: begin
                stateNext = STATE_NORMAL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_NORMAL;
        end else begin
            state <= stateNext;
        end
    end

    // Remember that this cycle's read belongs to the loader; the RAM
    // returns its data one cycle later. Reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspOwnerQ <= 1'b0;
        end else begin
            rspOwnerQ <= xferLd & (ld_we == '0);
        end
    end

    assign ld_rsp_valid = rspOwnerQ;
    assign ld_rsp_data  = mem_dout;
    assign cpu_rdata    = mem_dout;

endmodule
